// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with persistent SC/ZERO/GREATER flags, iterative shifts
// and an optional shift-add multiplier built only when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
  parameter int W   = 8,
  parameter int SHW = $clog2(W) + 1
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] INPUTA,
  input  logic [W-1:0] INPUTB,
  input  logic [3:0]   OP,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] OUT,
  output logic [W-1:0] OUT_HI,
  output logic         SC_OUT,
  output logic         ZERO,
  output logic         GREATER
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_MOV  = 4'd6,
    OP_LSH  = 4'd7,
    OP_RSH  = 4'd8,
    OP_ASR  = 4'd9,
    OP_COMP = 4'd10,
    OP_MUL  = 4'd11
  } opcode_t;

  localparam logic [W-1:0]   W_VAL = W'(W);
  localparam logic [SHW-1:0] W_CNT = SHW'(W);
  localparam logic [SHW-1:0] ONE   = SHW'(1);

  state_t         state, next_state;
  logic           accept;
  logic           multi;
  logic [SHW-1:0] shift_n;
  logic [SHW-1:0] cnt;
  logic [3:0]     op_r;

  logic [W:0]     sum;
  logic [W-1:0]   res;
  logic           res_sc, res_gt, res_zero;
  logic           set_sc, set_zero, set_gt;

  logic [W-1:0]   sh_r, sh_next;
  logic           sh_bit;
  logic [W-1:0]   fin_lo, fin_hi;
  logic           fin_sc;

  logic [W-1:0]   out_r, out_hi_r;
  logic           sc_r, zero_r, gt_r;

`ifdef ALU_SEQ_MUL_EN
  logic [W-1:0]   mcand_r, prod_hi_r, prod_lo_r;
  logic [W:0]     msum;
  logic [2*W-1:0] prod_next;
`endif

  assign accept  = IN_VALID & IN_READY;
  assign shift_n = (INPUTB >= W_VAL) ? W_CNT : INPUTB[SHW-1:0];

  // Single-cycle decode; multi flags ops that go through BUSY instead.
  always_comb begin
    sum      = '0;
    res      = '0;
    res_sc   = 1'b0;
    res_gt   = 1'b0;
    set_sc   = 1'b0;
    set_zero = 1'b0;
    set_gt   = 1'b0;
    multi    = 1'b0;
    case (OP)
      OP_ADD: begin
        sum      = {1'b0, INPUTA} + {1'b0, INPUTB};
        res      = sum[W-1:0];
        res_sc   = sum[W];
        set_sc   = 1'b1;
        set_zero = 1'b1;
      end
      OP_ADDC: begin
        sum      = {1'b0, INPUTA} + {1'b0, INPUTB} + {{W{1'b0}}, sc_r};
        res      = sum[W-1:0];
        res_sc   = sum[W];
        set_sc   = 1'b1;
        set_zero = 1'b1;
      end
      OP_SUB: begin
        sum      = {1'b0, INPUTA} - {1'b0, INPUTB};
        res      = sum[W-1:0];
        res_sc   = sum[W];
        set_sc   = 1'b1;
        set_zero = 1'b1;
      end
      OP_AND: begin
        res      = INPUTA & INPUTB;
        set_sc   = 1'b1;
        set_zero = 1'b1;
      end
      OP_OR: begin
        res      = INPUTA | INPUTB;
        set_sc   = 1'b1;
        set_zero = 1'b1;
      end
      OP_XOR: begin
        res      = INPUTA ^ INPUTB;
        set_sc   = 1'b1;
        set_zero = 1'b1;
      end
      OP_MOV: begin
        res      = INPUTA;
        set_sc   = 1'b1;
        set_zero = 1'b1;
      end
      OP_LSH, OP_RSH, OP_ASR: begin
        if (shift_n == '0) begin
          res      = INPUTA;
          set_sc   = 1'b1;
          set_zero = 1'b1;
        end else begin
          multi = 1'b1;
        end
      end
      OP_COMP: begin
        res_gt   = $signed(INPUTA) > $signed(INPUTB);
        set_gt   = 1'b1;
        set_zero = 1'b1;
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: multi = 1'b1;
`endif
      default: ;
    endcase
    res_zero = (OP == OP_COMP) ? (INPUTA == INPUTB) : (res == '0);
  end

  always_comb begin
    sh_next = sh_r;
    sh_bit  = 1'b0;
    case (op_r)
      OP_LSH: begin
        sh_next = {sh_r[W-2:0], 1'b0};
        sh_bit  = sh_r[W-1];
      end
      OP_RSH: begin
        sh_next = {1'b0, sh_r[W-1:1]};
        sh_bit  = sh_r[0];
      end
      OP_ASR: begin
        sh_next = {sh_r[W-1], sh_r[W-1:1]};
        sh_bit  = sh_r[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // One multiplier bit per cycle; the product shifts down through prod_lo_r.
  always_comb begin
    msum      = {1'b0, prod_hi_r} + (prod_lo_r[0] ? {1'b0, mcand_r} : '0);
    prod_next = {msum, prod_lo_r[W-1:1]};
  end
`endif

  always_comb begin
    fin_lo = sh_next;
    fin_hi = '0;
    fin_sc = sh_bit;
`ifdef ALU_SEQ_MUL_EN
    if (op_r == OP_MUL) begin
      fin_lo = prod_next[W-1:0];
      fin_hi = prod_next[2*W-1:W];
      fin_sc = |prod_next[2*W-1:W];
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = multi ? BUSY : DONE;
      BUSY: if (cnt == ONE) next_state = DONE;
      DONE: begin
        if (accept)         next_state = multi ? BUSY : DONE;
        else if (OUT_READY) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = (state == IDLE) | ((state == DONE) & OUT_READY);
    OUT_VALID = (state == DONE);
  end

  // Flags and results only change when entering DONE, so a reset in BUSY
  // leaves nothing half-committed.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      op_r      <= '0;
      cnt       <= '0;
      sh_r      <= '0;
      out_r     <= '0;
      out_hi_r  <= '0;
      sc_r      <= 1'b0;
      zero_r    <= 1'b0;
      gt_r      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_r   <= '0;
      prod_hi_r <= '0;
      prod_lo_r <= '0;
`endif
    end else if (accept) begin
      op_r <= OP;
      sh_r <= INPUTA;
`ifdef ALU_SEQ_MUL_EN
      mcand_r   <= INPUTA;
      prod_hi_r <= '0;
      prod_lo_r <= INPUTB;
      cnt       <= (OP == OP_MUL) ? W_CNT : shift_n;
`else
      cnt       <= shift_n;
`endif
      if (!multi) begin
        out_r    <= res;
        out_hi_r <= '0;
        if (set_sc)   sc_r   <= res_sc;
        if (set_zero) zero_r <= res_zero;
        if (set_gt)   gt_r   <= res_gt;
      end
    end else if (state == BUSY) begin
      cnt  <= cnt - ONE;
      sh_r <= sh_next;
`ifdef ALU_SEQ_MUL_EN
      {prod_hi_r, prod_lo_r} <= prod_next;
`endif
      if (cnt == ONE) begin
        out_r    <= fin_lo;
        out_hi_r <= fin_hi;
        sc_r     <= fin_sc;
        zero_r   <= (fin_lo == '0);
      end
    end
  end

  assign OUT     = out_r;
  assign OUT_HI  = out_hi_r;
  assign SC_OUT  = sc_r;
  assign ZERO    = zero_r;
  assign GREATER = gt_r;

endmodule
